// File: rtl/fsm_coverage_monitor.sv
// Watches an FSM state bus for coverage, transitions, illegal and stuck states,
// and streams a frozen 4-byte report over a valid/ready handshake.
module fsm_coverage_monitor #(
  parameter int STATE_W = 2,
  parameter logic [2**STATE_W-1:0] LEGAL_MASK = 4'b0111,
  parameter logic [2**(2*STATE_W)-1:0] TRANS_MASK = 16'h0112,
  parameter int STUCK_LIMIT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [STATE_W-1:0]      state_in,
  input  logic                    clear,
  output logic [2**STATE_W-1:0]   visited,
  output logic                    illegal_state,
  output logic                    illegal_trans,
  output logic                    stuck,
  output logic [15:0]             trans_count,
  input  logic                    rpt_req,
  output logic                    rpt_valid,
  output logic [7:0]              rpt_data,
  input  logic                    rpt_ready,
  output logic                    rpt_done
);

  localparam int DW = $clog2(STUCK_LIMIT + 1);
  localparam logic [DW-1:0] LIMIT = DW'(STUCK_LIMIT);

  typedef enum logic {R_IDLE, R_SEND} rpt_state_t;

  rpt_state_t rpt_st, rpt_nxt;
  logic [1:0] idx, idx_nxt;
  logic [3:0][7:0] snap, snap_nxt;
  logic done_nxt;

  logic [STATE_W-1:0] prev;
  logic prev_valid;
  logic [DW-1:0] dwell;
  logic err_state, err_trans;
  logic is_trans;
  logic unreached;

  assign is_trans  = prev_valid && (state_in != prev);
  assign stuck     = (dwell >= LIMIT);
  assign unreached = |(LEGAL_MASK & ~visited);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      visited       <= '0;
      trans_count   <= '0;
      dwell         <= '0;
      prev          <= '0;
      prev_valid    <= 1'b0;
      err_state     <= 1'b0;
      err_trans     <= 1'b0;
      illegal_state <= 1'b0;
      illegal_trans <= 1'b0;
    end else begin
      illegal_state <= 1'b0;
      illegal_trans <= 1'b0;
      if (en) begin
        visited[state_in] <= 1'b1;
        prev              <= state_in;
        prev_valid        <= 1'b1;
        if (!LEGAL_MASK[state_in]) begin
          illegal_state <= 1'b1;
          err_state     <= 1'b1;
        end
        if (is_trans) begin
          if (trans_count != 16'hFFFF)
            trans_count <= trans_count + 16'd1;
          dwell <= DW'(1);
          if (!TRANS_MASK[{prev, state_in}]) begin
            illegal_trans <= 1'b1;
            err_trans     <= 1'b1;
          end
        end else if (!prev_valid) begin
          dwell <= DW'(1);
        end else if (dwell < LIMIT) begin
          dwell <= dwell + DW'(1);
        end
      end
    end
  end

  // Report path is independent of clear so a snapshot survives it
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_st   <= R_IDLE;
      idx      <= '0;
      snap     <= '0;
      rpt_done <= 1'b0;
    end else begin
      rpt_st   <= rpt_nxt;
      idx      <= idx_nxt;
      snap     <= snap_nxt;
      rpt_done <= done_nxt;
    end
  end

  always_comb begin
    rpt_nxt  = rpt_st;
    idx_nxt  = idx;
    snap_nxt = snap;
    done_nxt = 1'b0;
    unique case (rpt_st)
      R_IDLE: begin
        if (rpt_req) begin
          rpt_nxt     = R_SEND;
          idx_nxt     = 2'd0;
          snap_nxt[0] = 8'(visited);
          snap_nxt[1] = {4'b0, stuck, err_trans, err_state, unreached};
          snap_nxt[2] = trans_count[15:8];
          snap_nxt[3] = trans_count[7:0];
        end
      end
      R_SEND: begin
        if (rpt_ready) begin
          idx_nxt = idx + 2'd1;
          if (idx == 2'd3) begin
            rpt_nxt  = R_IDLE;
            done_nxt = 1'b1;
          end
        end
      end
    endcase
  end

  assign rpt_valid = (rpt_st == R_SEND);
  assign rpt_data  = rpt_valid ? snap[idx] : 8'h00;

endmodule

// File: tb/tb_fsm_coverage_monitor.sv
// Bench for fsm_coverage_monitor: directed scenarios plus a randomized run,
// all checked against a behavioural model of the monitoring rules.
module tb_fsm_coverage_monitor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic [1:0] state_in = '0;
  logic clear = 1'b0;
  logic [3:0] visited;
  logic illegal_state, illegal_trans, stuck;
  logic [15:0] trans_count;
  logic rpt_req = 1'b0;
  logic rpt_valid;
  logic [7:0] rpt_data;
  logic rpt_ready = 1'b0;
  logic rpt_done;

  int checks = 0;
  int errors = 0;

  fsm_coverage_monitor dut (
    .clk(clk), .rst(rst), .en(en), .state_in(state_in), .clear(clear),
    .visited(visited), .illegal_state(illegal_state),
    .illegal_trans(illegal_trans), .stuck(stuck),
    .trans_count(trans_count), .rpt_req(rpt_req), .rpt_valid(rpt_valid),
    .rpt_data(rpt_data), .rpt_ready(rpt_ready), .rpt_done(rpt_done)
  );

  always #5 clk = ~clk;

  // Behavioural model
  bit m_vis[4];
  int unsigned m_cnt;
  bit m_have;
  int m_last;
  int m_run;
  bit m_es, m_et, m_is, m_it, m_done;
  logic [7:0] rq[$];

  function automatic bit legal_state(int s);
    return (s == 0) || (s == 1) || (s == 2);
  endfunction

  function automatic bit legal_step(int f, int t);
    return (f == 0 && t == 1) || (f == 1 && t == 0) || (f == 2 && t == 0);
  endfunction

  function automatic logic [3:0] m_visited();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_vis[i];
    return v;
  endfunction

  function automatic bit m_stuck();
    return m_run >= 16;
  endfunction

  function automatic logic [7:0] m_byte1();
    logic [7:0] b;
    b = 8'h00;
    b[3] = m_stuck();
    b[2] = m_et;
    b[1] = m_es;
    b[0] = !(m_vis[0] && m_vis[1] && m_vis[2]);
    return b;
  endfunction

  task automatic tick();
    logic [15:0] c;
    int s;
    @(posedge clk);
    m_done = 0;
    if (rst) begin
      rq.delete();
    end else if (rq.size() > 0) begin
      if (rpt_ready) begin
        void'(rq.pop_front());
        if (rq.size() == 0) m_done = 1;
      end
    end else if (rpt_req) begin
      c = 16'(m_cnt);
      rq.push_back(8'(m_visited()));
      rq.push_back(m_byte1());
      rq.push_back(c[15:8]);
      rq.push_back(c[7:0]);
    end
    m_is = 0;
    m_it = 0;
    s = int'(state_in);
    if (rst || clear) begin
      for (int i = 0; i < 4; i++) m_vis[i] = 0;
      m_cnt = 0; m_have = 0; m_run = 0; m_es = 0; m_et = 0;
    end else if (en) begin
      if (!legal_state(s)) begin m_is = 1; m_es = 1; end
      if (m_have && s != m_last) begin
        if (m_cnt < 65535) m_cnt++;
        m_run = 1;
        if (!legal_step(m_last, s)) begin m_it = 1; m_et = 1; end
      end else if (!m_have) begin
        m_run = 1;
      end else if (m_run < 16) begin
        m_run++;
      end
      m_vis[s] = 1;
      m_last = s;
      m_have = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    checks++; if (visited !== 4'h0) begin errors++; $display("FAIL reset_visited got %h want 0", visited); end
    checks++; if (trans_count !== 16'h0) begin errors++; $display("FAIL reset_count got %h want 0", trans_count); end
    checks++; if (stuck !== 1'b0 || illegal_state !== 1'b0 || illegal_trans !== 1'b0) begin
      errors++; $display("FAIL reset_flags got %b%b%b want 000", stuck, illegal_state, illegal_trans); end
    checks++; if (rpt_valid !== 1'b0 || rpt_done !== 1'b0) begin
      errors++; $display("FAIL reset_rpt got %b%b want 00", rpt_valid, rpt_done); end
  endtask

  task automatic test_sequence();
    int seq[6] = '{0, 1, 0, 1, 2, 0};
    int nit = 0, nis = 0;
    rst = 1; tick(); rst = 0;
    en = 1;
    foreach (seq[i]) begin
      state_in = 2'(seq[i]);
      tick();
      checks++; if (illegal_trans !== m_it || illegal_state !== m_is) begin errors++;
        $display("FAIL seq_pulses step %0d got %b%b want %b%b", i, illegal_trans, illegal_state, m_it, m_is); end
      if (illegal_trans === 1'b1) nit++;
      if (illegal_state === 1'b1) nis++;
    end
    en = 0; tick();
    checks++; if (visited !== 4'b0111) begin errors++; $display("FAIL seq_visited got %b want 0111", visited); end
    checks++; if (trans_count !== 16'(m_cnt)) begin errors++; $display("FAIL seq_count got %0d want %0d", trans_count, m_cnt); end
    checks++; if (nit != 1 || nis != 0) begin errors++; $display("FAIL seq_pulse_count got %0d/%0d want 1/0", nit, nis); end
  endtask

  task automatic test_report_stall();
    logic [7:0] first;
    int ndone = 0;
    rpt_ready = 0; rpt_req = 1; tick(); rpt_req = 0;
    first = rpt_data;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rpt_valid !== 1'b1 || rpt_data !== rq[0] || rpt_data !== first) begin errors++;
        $display("FAIL stall_hold cyc %0d got v=%b d=%h want v=1 d=%h", i, rpt_valid, rpt_data, rq[0]); end
    end
    clear = 1; tick(); clear = 0;
    checks++; if (rpt_data !== first || trans_count !== 16'h0) begin errors++;
      $display("FAIL stall_clear got d=%h cnt=%h want d=%h cnt=0", rpt_data, trans_count, first); end
    rpt_ready = 1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (rpt_valid !== (rq.size() > 0) || (rq.size() > 0 && rpt_data !== rq[0])) begin errors++;
        $display("FAIL stall_byte cyc %0d got v=%b d=%h want v=%b", i, rpt_valid, rpt_data, rq.size() > 0); end
      tick();
      checks++; if (rpt_done !== m_done) begin errors++; $display("FAIL stall_done cyc %0d got %b want %b", i, rpt_done, m_done); end
      if (rpt_done === 1'b1) ndone++;
    end
    rpt_ready = 0;
    checks++; if (ndone != 1) begin errors++; $display("FAIL stall_done_count got %0d want 1", ndone); end
  endtask

  task automatic test_illegal_state();
    logic [7:0] got[$];
    en = 1;
    for (int s = 0; s < 4; s++) begin
      state_in = 2'(s); tick();
    end
    en = 0;
    checks++; if (illegal_state !== 1'b1 || visited[3] !== 1'b1) begin errors++;
      $display("FAIL illegal_state got pulse=%b vis3=%b want 1/1", illegal_state, visited[3]); end
    tick();
    checks++; if (illegal_state !== 1'b0) begin errors++; $display("FAIL illegal_state_width got %b want 0", illegal_state); end
    rpt_ready = 1; rpt_req = 1; tick(); rpt_req = 0;
    for (int i = 0; i < 10; i++) begin
      if (rpt_valid === 1'b1) got.push_back(rpt_data);
      tick();
    end
    rpt_ready = 0;
    checks++; if (got.size() != 4) begin errors++; $display("FAIL illegal_rpt_len got %0d want 4", got.size()); end
    else begin
      checks++; if (got[1][1:0] !== 2'b10) begin errors++; $display("FAIL illegal_rpt_byte1 got %b want 10", got[1][1:0]); end
    end
  endtask

  task automatic test_stuck();
    clear = 1; tick(); clear = 0;
    en = 1; state_in = 2'd0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++; if (stuck !== (i >= 16) || stuck !== m_stuck()) begin errors++;
        $display("FAIL stuck_rise sample %0d got %b want %b", i, stuck, i >= 16); end
    end
    state_in = 2'd1; tick(); en = 0;
    checks++; if (stuck !== 1'b0 || trans_count !== 16'd1 || illegal_trans !== 1'b0) begin errors++;
      $display("FAIL stuck_fall got s=%b c=%0d it=%b want 0/1/0", stuck, trans_count, illegal_trans); end
  endtask

  task automatic test_saturation();
    clear = 1; tick(); clear = 0;
    en = 1;
    for (int i = 0; i < 65535; i++) begin
      state_in = 2'(i % 2); tick();
    end
    checks++; if (trans_count !== 16'hFFFE || trans_count !== 16'(m_cnt)) begin errors++;
      $display("FAIL sat_preload got %h want fffe", trans_count); end
    for (int k = 0; k < 3; k++) begin
      state_in = 2'((k + 1) % 2); tick();
      checks++; if (trans_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold step %0d got %h want ffff", k, trans_count); end
    end
    en = 0;
  endtask

  task automatic test_reset_mid_report();
    logic [7:0] want[4] = '{8'h00, 8'h01, 8'h00, 8'h00};
    logic [7:0] got[$];
    rpt_ready = 1; rpt_req = 1; tick(); rpt_req = 0;
    tick(); tick();
    rst = 1; tick(); rst = 0;
    checks++; if (rpt_valid !== 1'b0 || trans_count !== 16'h0 || visited !== 4'h0 || stuck !== 1'b0) begin errors++;
      $display("FAIL rst_mid got v=%b c=%h vis=%b s=%b want 0", rpt_valid, trans_count, visited, stuck); end
    rpt_req = 1; tick(); rpt_req = 0;
    for (int i = 0; i < 10; i++) begin
      if (rpt_valid === 1'b1) got.push_back(rpt_data);
      tick();
    end
    rpt_ready = 0;
    checks++; if (got.size() != 4) begin errors++; $display("FAIL rst_rpt_len got %0d want 4", got.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== want[i] || got[i] !== rq_hist_dummy(i, got[i])) begin errors++;
        $display("FAIL rst_rpt_byte%0d got %h want %h", i, got[i], want[i]); end
    end
  endtask

  function automatic logic [7:0] rq_hist_dummy(int i, logic [7:0] v);
    return (i >= 0) ? v : 8'h00;
  endfunction

  task automatic test_random();
    for (int n = 0; n < 2500; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      clear     = ($urandom_range(0, 49) == 0);
      en        = ($urandom_range(0, 9) < 7);
      state_in  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && n % 40 < 20) state_in = 2'(m_last);
      rpt_req   = ($urandom_range(0, 19) == 0);
      rpt_ready = $urandom_range(0, 1) == 1;
      tick();
      checks++; if (visited !== m_visited() || trans_count !== 16'(m_cnt)) begin errors++;
        $display("FAIL rnd_cov cyc %0d got %b/%0d want %b/%0d", n, visited, trans_count, m_visited(), m_cnt); end
      checks++; if (illegal_state !== m_is || illegal_trans !== m_it || stuck !== m_stuck()) begin errors++;
        $display("FAIL rnd_flags cyc %0d got %b%b%b want %b%b%b", n, illegal_state, illegal_trans, stuck, m_is, m_it, m_stuck()); end
      checks++; if (rpt_valid !== (rq.size() > 0) || rpt_done !== m_done) begin errors++;
        $display("FAIL rnd_rpt cyc %0d got v=%b d=%b want v=%b d=%b", n, rpt_valid, rpt_done, rq.size() > 0, m_done); end
      if (rq.size() > 0) begin
        checks++; if (rpt_data !== rq[0]) begin errors++;
          $display("FAIL rnd_data cyc %0d got %h want %h", n, rpt_data, rq[0]); end
      end
    end
    rst = 0; clear = 0; en = 0; rpt_req = 0; rpt_ready = 0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_report_stall();
    test_illegal_state();
    test_stuck();
    test_saturation();
    test_reset_mid_report();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
